// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_pkg
//  Description : Shared constants for the SPI slave shift engine:
//                byte width, synchronizer depth and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    localparam int c_BYTE_W      = 8;
    localparam int c_SYNC_STAGES = 2;

    // Encodings are visible on the spi_state output port.
    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_SHIFT = 2'b01;

endpackage : spi_slave_pkg
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_sync
//  Description : Synchronizer chain for one asynchronous pin, followed by a
//                history flop used for edge detection.
//  Ports       : clk, reset  - core clock, synchronous active-high reset
//                i_async     - asynchronous pin
//                o_sync      - synchronized level
//                o_rise      - synchronized level went 0 -> 1 this cycle
//                o_fall      - synchronized level went 1 -> 0 this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync
    import spi_slave_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [c_SYNC_STAGES-1:0] r_sync;
    logic                     r_hist;

    // All stages reset to 0: a pin that is already low after reset never
    // produces a falling edge, so a frame in progress is not re-entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[c_SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[c_SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[c_SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_hist;
    assign o_fall = ~o_sync & r_hist;

endmodule : spi_slave_sync
`default_nettype wire

// File: rtl/spi_slave_io.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_io
//  Description : SPI slave shift engine. Oversamples sclk/ss/mosi in the clk
//                domain, assembles received bytes and shifts tx_data out on
//                miso. Supports all CPOL/CPHA modes and MSB/LSB-first order.
//  Ports       : clk, reset          - core clock, sync active-high reset
//                spi_en              - block enable (low: ignore pins)
//                cpol, cpha          - SPI mode
//                lsbfirst            - bit 0 first on mosi and miso
//                sclk, ss, mosi      - asynchronous pins from the master
//                miso                - serial data to the master
//                tx_data / tx_read   - next tx byte / pulse when it is loaded
//                rx_data / rx_access - last rx byte / pulse when it updates
//                spi_state           - 00 IDLE, 01 SHIFT
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_io
    import spi_slave_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                spi_en,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsbfirst,
    input  logic                sclk,
    input  logic                ss,
    input  logic                mosi,
    output logic                miso,
    input  logic [c_BYTE_W-1:0] tx_data,
    output logic                tx_read,
    output logic [c_BYTE_W-1:0] rx_data,
    output logic                rx_access,
    output logic [1:0]          spi_state
);

    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_ss, w_ss_rise, w_ss_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_slave_sync u_sync_sclk (
        .clk(clk), .reset(reset), .i_async(sclk),
        .o_sync(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_slave_sync u_sync_ss (
        .clk(clk), .reset(reset), .i_async(ss),
        .o_sync(w_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_slave_sync u_sync_mosi (
        .clk(clk), .reset(reset), .i_async(mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // Only the mosi level, the ss level/fall and the sclk edges matter.
    logic w_unused;
    assign w_unused = &{1'b0, w_sclk, w_ss_rise, w_mosi_rise, w_mosi_fall};

    logic [1:0]          r_state;
    logic [2:0]          r_bit_cnt;
    logic                r_byte_done;
    logic [c_BYTE_W-1:0] r_rx_sr;
    logic [c_BYTE_W-1:0] r_tx_sr;
    logic [c_BYTE_W-1:0] r_rx_data;
    logic                r_rx_access;
    logic                r_tx_read;
    logic                r_miso;

    // Leading edge leaves the idle level, trailing edge returns to it.
    logic w_lead, w_trail, w_sample, w_shift;
    assign w_lead   = cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample = cpha ? w_trail : w_lead;
    assign w_shift  = cpha ? w_lead  : w_trail;

    logic [c_BYTE_W-1:0] w_rx_next;
    logic [c_BYTE_W-1:0] w_tx_next;
    logic                w_load_bit;
    logic                w_next_bit;
    assign w_rx_next  = lsbfirst ? {w_mosi, r_rx_sr[c_BYTE_W-1:1]}
                                 : {r_rx_sr[c_BYTE_W-2:0], w_mosi};
    assign w_tx_next  = lsbfirst ? {1'b0, r_tx_sr[c_BYTE_W-1:1]}
                                 : {r_tx_sr[c_BYTE_W-2:0], 1'b0};
    assign w_load_bit = lsbfirst ? tx_data[0]   : tx_data[c_BYTE_W-1];
    assign w_next_bit = lsbfirst ? w_tx_next[0] : w_tx_next[c_BYTE_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_rx_data   <= '0;
            r_rx_access <= 1'b0;
            r_tx_read   <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_rx_access <= 1'b0;
            r_tx_read   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_bit_cnt   <= 3'd0;
                    r_byte_done <= 1'b0;
                    r_miso      <= 1'b0;
                    // sclk edges coinciding with the ss fall are ignored.
                    if (spi_en && w_ss_fall) begin
                        r_state <= c_ST_SHIFT;
                        if (!cpha) begin
                            r_tx_sr   <= tx_data;
                            r_miso    <= w_load_bit;
                            r_tx_read <= 1'b1;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    // Deselect or disable has priority over any sclk edge.
                    if (w_ss || !spi_en) begin
                        r_state     <= c_ST_IDLE;
                        r_bit_cnt   <= 3'd0;
                        r_byte_done <= 1'b0;
                        r_miso      <= 1'b0;
                    end else if (w_sample) begin
                        r_rx_sr   <= w_rx_next;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_data   <= w_rx_next;
                            r_rx_access <= 1'b1;
                            r_byte_done <= 1'b1;
                        end
                    end else if (w_shift) begin
                        r_byte_done <= 1'b0;
                        // CPHA=1 loads on the first shift edge of each byte;
                        // CPHA=0 already loaded at ss fall, so it reloads
                        // only on the shift edge that follows a full byte.
                        if (r_bit_cnt == 3'd0 && (cpha || r_byte_done)) begin
                            r_tx_sr   <= tx_data;
                            r_miso    <= w_load_bit;
                            r_tx_read <= 1'b1;
                        end else begin
                            r_tx_sr <= w_tx_next;
                            r_miso  <= w_next_bit;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign miso      = r_miso & spi_en;
    assign tx_read   = r_tx_read;
    assign rx_data   = r_rx_data;
    assign rx_access = r_rx_access;
    assign spi_state = r_state;

endmodule : spi_slave_io
`default_nettype wire
